// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the master and the target: FSM state
// encodings, ACK/NACK bus levels and the default target address.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_A,
      ST_PTR,
      ST_ACK_P,
      ST_WDATA,
      ST_ACK_W,
      ST_TX,
      ST_MACK,
      ST_WAIT
   } i2cState;

   localparam logic       ACK              = 1'b0;
   localparam logic       NACK             = 1'b1;
   localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h4B;
   localparam logic [3:0] BITS_PER_BYTE    = 4'd8;

   // A byte is complete once eight rising scl edges have been counted.
   function automatic logic byteDone(input logic [3:0] bitCnt);
      return bitCnt == BITS_PER_BYTE;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser for one I2C line followed by an edge register that produces
// single-cycle rise/fall pulses from the synchronised level.
module i2c_line_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic lineIn,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] syncReg;
   logic              edgeReg;

   // Idle I2C lines sit high, so the chain resets to 1 to avoid a false edge
   // straight out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncReg <= '1;
         edgeReg <= 1'b1;
      end else begin
         syncReg <= {syncReg[STAGES-2:0], lineIn};
         edgeReg <= syncReg[STAGES-1];
      end
   end

   assign level = syncReg[STAGES-1];
   assign rise  = syncReg[STAGES-1] & ~edgeReg;
   assign fall  = ~syncReg[STAGES-1] & edgeReg;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a pointer-addressed register space on scl/sda.
// Define I2C_TGT_REG_WRITE_EN to accept register writes after the pointer byte.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

`ifdef I2C_TGT_REG_WRITE_EN
   localparam logic WRITE_EN = 1'b1;
`else
   localparam logic WRITE_EN = 1'b0;
`endif

   i2cState    state;
   i2cState    nextState;
   logic       sclLevel, sclRise, sclFall;
   logic       sdaLevel, sdaRise, sdaFall;
   logic       startEvt, stopEvt;
   logic [7:0] shiftReg;
   logic [7:0] byteIn;
   logic [3:0] bitCnt;
   logic [7:0] rdAddr;
   logic       masterAck;
   logic       sdaOe, sdaOeNext;
   logic       busyReg;

   i2c_line_sync #(.STAGES(SYNC_STAGES)) sclSync (
      .clk    (clk),
      .reset  (reset),
      .lineIn (scl),
      .level  (sclLevel),
      .rise   (sclRise),
      .fall   (sclFall)
   );

   i2c_line_sync #(.STAGES(SYNC_STAGES)) sdaSync (
      .clk    (clk),
      .reset  (reset),
      .lineIn (sda),
      .level  (sdaLevel),
      .rise   (sdaRise),
      .fall   (sdaFall)
   );

   assign startEvt = sdaFall & sclLevel;
   assign stopEvt  = sdaRise & sclLevel;
   assign byteIn   = {shiftReg[6:0], sdaLevel};

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= nextState;
   end

   // Next-state logic; STOP beats START, and both beat any bit-level event.
   always_comb begin
      nextState = state;
      if (stopEvt) begin
         nextState = ST_IDLE;
      end else if (startEvt) begin
         nextState = ST_ADDR;
      end else if (sclFall) begin
         case (state)
            ST_ADDR:  if (byteDone(bitCnt)) nextState = (shiftReg[7:1] == DEV_ADDR) ? ST_ACK_A : ST_IDLE;
            ST_ACK_A: nextState = shiftReg[0] ? ST_TX : ST_PTR;
            ST_PTR:   if (byteDone(bitCnt)) nextState = ST_ACK_P;
            ST_ACK_P: nextState = ST_WDATA;
            ST_WDATA: if (byteDone(bitCnt)) nextState = WRITE_EN ? ST_ACK_W : ST_WAIT;
            ST_ACK_W: nextState = ST_WDATA;
            ST_TX:    if (byteDone(bitCnt)) nextState = ST_MACK;
            ST_MACK:  nextState = (masterAck == NACK) ? ST_WAIT : ST_TX;
            default:  nextState = state;
         endcase
      end
   end

   // Open-drain drive only changes on an scl fall, so sda is stable while scl is high.
   always_comb begin
      sdaOeNext = sdaOe;
      if (stopEvt || startEvt) begin
         sdaOeNext = 1'b0;
      end else if (sclFall) begin
         case (nextState)
            ST_ACK_A, ST_ACK_P, ST_ACK_W: sdaOeNext = 1'b1;
            ST_TX:   sdaOeNext = (state == ST_TX) ? ~shiftReg[6] : ~rd_data[7];
            default: sdaOeNext = 1'b0;
         endcase
      end
   end

   // Datapath: shifting, bit counting, pointer updates and the busy flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sdaOe     <= 1'b0;
         shiftReg  <= '0;
         bitCnt    <= '0;
         rdAddr    <= '0;
         masterAck <= NACK;
         busyReg   <= 1'b0;
      end else begin
         sdaOe <= sdaOeNext;
         if (stopEvt) begin
            busyReg <= 1'b0;
         end else if (startEvt) begin
            busyReg <= 1'b0;
            bitCnt  <= '0;
         end else begin
            case (state)
               ST_ADDR, ST_PTR, ST_WDATA: begin
                  if (sclRise && !byteDone(bitCnt)) begin
                     shiftReg <= byteIn;
                     bitCnt   <= bitCnt + 4'd1;
                     if (WRITE_EN && state == ST_WDATA && bitCnt == 4'd7) rdAddr <= rdAddr + 8'd1;
                  end
                  if (sclFall && byteDone(bitCnt)) begin
                     if (state == ST_ADDR && nextState == ST_ACK_A) busyReg <= 1'b1;
                     if (state == ST_PTR) rdAddr <= shiftReg;
                  end
               end
               ST_ACK_A, ST_ACK_P, ST_ACK_W: begin
                  if (sclFall) begin
                     bitCnt <= '0;
                     if (nextState == ST_TX) shiftReg <= rd_data;
                  end
               end
               ST_TX: begin
                  if (sclRise && !byteDone(bitCnt)) bitCnt <= bitCnt + 4'd1;
                  if (sclFall && !byteDone(bitCnt)) shiftReg <= {shiftReg[6:0], 1'b0};
               end
               ST_MACK: begin
                  if (sclRise) begin
                     masterAck <= sdaLevel;
                     if (sdaLevel == ACK) rdAddr <= rdAddr + 8'd1;
                  end
                  if (sclFall && nextState == ST_TX) begin
                     shiftReg <= rd_data;
                     bitCnt   <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef I2C_TGT_REG_WRITE_EN
   logic       wrEnReg;
   logic [7:0] wrAddrReg, wrDataReg;

   // A write is captured on the 8th rising edge, addressed by the pointer
   // before its post-write increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrEnReg   <= 1'b0;
         wrAddrReg <= '0;
         wrDataReg <= '0;
      end else begin
         wrEnReg <= 1'b0;
         if (state == ST_WDATA && sclRise && bitCnt == 4'd7 && !startEvt && !stopEvt) begin
            wrEnReg   <= 1'b1;
            wrAddrReg <= rdAddr;
            wrDataReg <= byteIn;
         end
      end
   end

   assign wr_en   = wrEnReg;
   assign wr_addr = wrAddrReg;
   assign wr_data = wrDataReg;
`else
   assign wr_en   = 1'b0;
   assign wr_addr = '0;
   assign wr_data = '0;
`endif

   assign sda     = sdaOe ? 1'b0 : 1'bz;
   assign rd_addr = rdAddr;
   assign busy    = busyReg;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master with an expected-value
// scoreboard drained by an independent monitor process.
module tb_i2c_target;

   typedef struct {
      string      name;
      logic [7:0] value;
   } scoreItem;

   logic       clk;
   logic       reset;
   logic       scl;
   logic       masterLow;
   wire        sda;
   logic [7:0] rdAddr;
   logic [7:0] rdData;
   logic       wrEn;
   logic [7:0] wrAddr;
   logic [7:0] wrData;
   logic       busy;

   scoreItem   expQ[$];
   scoreItem   obsQ[$];
   logic [15:0] wrExpQ[$];
   int         checks = 0;
   int         passed = 0;

   i2c_target dut (
      .clk     (clk),
      .reset   (reset),
      .scl     (scl),
      .sda     (sda),
      .rd_addr (rdAddr),
      .rd_data (rdData),
      .wr_en   (wrEn),
      .wr_addr (wrAddr),
      .wr_data (wrData),
      .busy    (busy)
   );

   assign sda = masterLow ? 1'b0 : 1'bz;
   pullup (sda);

   // Register file model: byte at address a is a ^ 0x5A.
   assign rdData = rdAddr ^ 8'h5A;

   // 100 MHz system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expectValue(input string name, input logic [7:0] value);
      scoreItem it;
      it.name  = name;
      it.value = value;
      expQ.push_back(it);
   endtask

   task automatic observe(input string name, input logic [7:0] value);
      scoreItem it;
      it.name  = name;
      it.value = value;
      obsQ.push_back(it);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
      checks++;
      if (actual === required) passed++;
      else $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, required);
   endtask

   // One scl period: set data while scl is low, sample mid-high.
   task automatic applyStimulus(input logic bitVal, output logic sampled);
      waitClk(8);
      masterLow = ~bitVal;
      waitClk(4);
      scl = 1'b1;
      waitClk(10);
      sampled = sda;
      waitClk(10);
      scl = 1'b0;
   endtask

   task automatic sendStart();
      waitClk(8);
      masterLow = 1'b0;
      waitClk(8);
      scl = 1'b1;
      waitClk(10);
      masterLow = 1'b1;
      waitClk(10);
      scl = 1'b0;
   endtask

   task automatic sendStop();
      waitClk(8);
      masterLow = 1'b1;
      waitClk(8);
      scl = 1'b1;
      waitClk(10);
      masterLow = 1'b0;
      waitClk(10);
   endtask

   task automatic writeByte(input logic [7:0] b, input string ackName);
      logic s, ack;
      for (int i = 7; i >= 0; i--) applyStimulus(b[i], s);
      applyStimulus(1'b1, ack);
      observe(ackName, {7'd0, ack});
   endtask

   task automatic readByte(input logic ackBit, input string name);
      logic [7:0] d;
      logic       s;
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(1'b1, s);
         d[i] = s;
      end
      applyStimulus(ackBit, s);
      observe(name, d);
   endtask

   // Monitor: pairs each DUT observation with the oldest expectation, and
   // checks every write strobe against the expected write queue.
   initial begin : monitor
      forever begin
         @(negedge clk);
         while (obsQ.size() > 0) begin
            scoreItem ob;
            scoreItem ex;
            ob = obsQ.pop_front();
            if (expQ.size() == 0) begin
               checks++;
               $display("[TB] FAIL %s: got %02h, expected nothing", ob.name, ob.value);
            end else begin
               ex = expQ.pop_front();
               checkOutput(ex.name, ob.value, ex.value);
            end
         end
         if (wrEn) begin
            if (wrExpQ.size() == 0) begin
               checks++;
               $display("[TB] FAIL wrStrobe: got addr %02h data %02h, expected no write", wrAddr, wrData);
            end else begin
               logic [15:0] w;
               w = wrExpQ.pop_front();
               checkOutput("wrAddr", wrAddr, w[15:8]);
               checkOutput("wrData", wrData, w[7:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #900_000;
      $display("[TB] FAIL watchdog: time limit reached, %0d of %0d checks passed so far", passed, checks);
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      logic s;
      reset     = 1'b1;
      scl       = 1'b1;
      masterLow = 1'b0;

      // Reset state.
      waitClk(3);
      expectValue("rstRdAddr", 8'h00); observe("rstRdAddr", rdAddr);
      expectValue("rstBusy",   8'h00); observe("rstBusy",   {7'd0, busy});
      expectValue("rstWrEn",   8'h00); observe("rstWrEn",   {7'd0, wrEn});
      expectValue("rstWrAddr", 8'h00); observe("rstWrAddr", wrAddr);
      expectValue("rstWrData", 8'h00); observe("rstWrData", wrData);
      expectValue("rstSda",    8'h01); observe("rstSda",    {7'd0, sda});
      reset = 1'b0;
      waitClk(5);

      $display("[TB] reset during a read byte");
      sendStart();
      expectValue("rdAddrAck", 8'h00);
      writeByte(8'h97, "rdAddrAck");
      expectValue("busyAfterMatch", 8'h01); observe("busyAfterMatch", {7'd0, busy});
      expectValue("txBit7", 8'h00);
      applyStimulus(1'b1, s); observe("txBit7", {7'd0, s});
      expectValue("txBit6", 8'h01);
      applyStimulus(1'b1, s); observe("txBit6", {7'd0, s});
      waitClk(8);
      expectValue("txBit5Drive", 8'h00); observe("txBit5Drive", {7'd0, sda});
      reset = 1'b1;
      waitClk(1);
      expectValue("sdaReleased", 8'h01); observe("sdaReleased", {7'd0, sda});
      expectValue("rdAddrAfterRst", 8'h00); observe("rdAddrAfterRst", rdAddr);
      reset = 1'b0;
      waitClk(4);
      scl = 1'b1;
      waitClk(10);

      $display("[TB] pointer write 0x0B");
      sendStart();
      expectValue("wrAddrAck", 8'h00); writeByte(8'h96, "wrAddrAck");
      expectValue("busyWrite", 8'h01); observe("busyWrite", {7'd0, busy});
      expectValue("ptrAck", 8'h00); writeByte(8'h0B, "ptrAck");
      sendStop();
      expectValue("ptrValue", 8'h0B); observe("ptrValue", rdAddr);
      expectValue("busyStop", 8'h00); observe("busyStop", {7'd0, busy});

      $display("[TB] pointer write, repeated start, two-byte read");
      sendStart();
      expectValue("addrAck2", 8'h00); writeByte(8'h96, "addrAck2");
      expectValue("ptrAck2", 8'h00); writeByte(8'h0B, "ptrAck2");
      sendStart();
      expectValue("rdAck2", 8'h00); writeByte(8'h97, "rdAck2");
      expectValue("readByte0B", 8'h51); readByte(1'b0, "readByte0B");
      expectValue("readByte0C", 8'h56); readByte(1'b1, "readByte0C");
      sendStop();
      expectValue("ptrAfterRead", 8'h0C); observe("ptrAfterRead", rdAddr);

      $display("[TB] wrong address");
      sendStart();
      expectValue("badAddrNack", 8'h01); writeByte(8'h90, "badAddrNack");
      expectValue("busyBadAddr", 8'h00); observe("busyBadAddr", {7'd0, busy});
      expectValue("ignoredByte", 8'h01); writeByte(8'h96, "ignoredByte");
      expectValue("busyIgnored", 8'h00); observe("busyIgnored", {7'd0, busy});
      sendStop();

      $display("[TB] pointer wrap");
      sendStart();
      expectValue("addrAck3", 8'h00); writeByte(8'h96, "addrAck3");
      expectValue("ptrAckFF", 8'h00); writeByte(8'hFF, "ptrAckFF");
      sendStart();
      expectValue("rdAck3", 8'h00); writeByte(8'h97, "rdAck3");
      expectValue("readByteFF", 8'hA5); readByte(1'b0, "readByteFF");
      expectValue("readByte00", 8'h5A); readByte(1'b1, "readByte00");
      sendStop();
      expectValue("ptrWrapped", 8'h00); observe("ptrWrapped", rdAddr);

      $display("[TB] register write bytes");
      sendStart();
      expectValue("addrAck4", 8'h00); writeByte(8'h96, "addrAck4");
      expectValue("ptrAck10", 8'h00); writeByte(8'h10, "ptrAck10");
`ifdef I2C_TGT_REG_WRITE_EN
      wrExpQ.push_back(16'h10A5);
      wrExpQ.push_back(16'h115A);
      expectValue("dataAckA5", 8'h00); writeByte(8'hA5, "dataAckA5");
      expectValue("dataAck5A", 8'h00); writeByte(8'h5A, "dataAck5A");
      sendStop();
      expectValue("ptrAfterWrite", 8'h12); observe("ptrAfterWrite", rdAddr);
`else
      expectValue("dataNackA5", 8'h01); writeByte(8'hA5, "dataNackA5");
      expectValue("dataIgnored5A", 8'h01); writeByte(8'h5A, "dataIgnored5A");
      sendStop();
      expectValue("ptrAfterWrite", 8'h10); observe("ptrAfterWrite", rdAddr);
`endif

      waitClk(20);
      while (expQ.size() > 0) begin
         scoreItem it;
         it = expQ.pop_front();
         checks++;
         $display("[TB] FAIL %s: got no observation, expected %02h", it.name, it.value);
      end
      while (wrExpQ.size() > 0) begin
         logic [15:0] w;
         w = wrExpQ.pop_front();
         checks++;
         $display("[TB] FAIL wrStrobe: got no write, expected addr %02h data %02h", w[15:8], w[7:0]);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
